// File: rtl/ro_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ro_meter_pkg
// Purpose : Shared types and default parameter constants for the
//           ring-oscillator frequency meter (ro_freq_meter, ro_sync_edge).
// Contents: state_t   - measurement FSM state encoding
//           DEF_*     - default values for the top-level parameters
// Revision: 1.0 - initial release
// ============================================================================
package ro_meter_pkg;

  // Measurement FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_NUM_CH      = 16;
  localparam int DEF_WIN_W       = 16;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_SYNC_STAGES = 2;

endpackage : ro_meter_pkg
`default_nettype wire

// File: rtl/ro_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : ro_sync_edge
// Purpose : SYNC_STAGES-deep synchronizer for one asynchronous oscillator
//           signal, followed by a previous-sample register used for rising
//           edge detection.
// Ports   : clk       - sampling clock
//           rst       - synchronous active-high reset (all flops to 0)
//           async_i   - asynchronous input (selected oscillator)
//           load_prev - copy synchronizer output into the previous-sample
//                       register without reporting an edge
//           count_en  - counting window active; enables edge_o and keeps
//                       the previous-sample register tracking
//           edge_o    - rising edge seen this cycle (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  input  logic load_prev,
  input  logic count_en,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = prev_q;
    // prev tracks the synchronizer only while it matters; loading it at the
    // end of settling means the first counted cycle compares like with like.
    if (load_prev || count_en) begin
      prev_d = sync_out;
    end
  end

  assign edge_o = count_en & sync_out & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule : ro_sync_edge
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module  : ro_freq_meter
// Purpose : N-channel ring-oscillator frequency meter. Selects one of NUM_CH
//           oscillators, synchronizes it, and counts its rising edges over a
//           programmable window of wb_clk_i cycles. The raw selected
//           oscillator is also forwarded combinationally on mux_out.
// Ports   : wb_clk_i  - clock
//           wb_rst_i  - synchronous active-high reset
//           ro_in     - asynchronous oscillator outputs
//           sel       - channel to measure / channel driven onto mux_out
//           win_len   - window length in cycles (sampled on accepted start)
//           start     - measurement request, accepted only in IDLE
//           busy      - measurement in progress
//           done      - one-cycle pulse when a result is published
//           count     - rising edges counted in the last window (saturating)
//           count_ch  - channel that count belongs to
//           overflow  - last window saturated count
//           mux_out   - raw ro_in[sel], 0 for sel >= NUM_CH
// Config  : RO_FREQ_METER_AUTO_SCAN_EN - when defined, an accepted start scans
//           from sel up to NUM_CH-1, publishing one result per channel.
// Notes   : Results are valid only for oscillator frequencies below half the
//           clock frequency; faster inputs alias.
// Revision: 1.0 - initial release
// ============================================================================
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int WIN_W       = DEF_WIN_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic [CH_W-1:0]   sel,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [CH_W-1:0]   count_ch,
  output logic              overflow,
  output logic              mux_out
);

  localparam int NPAD  = 1 << CH_W;
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SYNC_STAGES);
`ifdef RO_FREQ_METER_AUTO_SCAN_EN
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
`endif

  // Pad the oscillator vector to a power of two so out-of-range channel
  // indices read a constant 0 instead of indexing past the port.
  logic [NPAD-1:0] ro_pad;

  generate
    if (NPAD > NUM_CH) begin : g_pad
      assign ro_pad = {{(NPAD - NUM_CH){1'b0}}, ro_in};
    end else begin : g_nopad
      assign ro_pad = ro_in;
    end
  endgenerate

  assign mux_out = ro_pad[sel];

  state_t             state_q,    state_d;
  logic [CH_W-1:0]    ch_q,       ch_d;
  logic [WIN_W-1:0]   win_q,      win_d;
  logic [WIN_W-1:0]   win_rem_q,  win_rem_d;
  logic [SET_W-1:0]   settle_q,   settle_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_q,      ovf_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [CH_W-1:0]    count_ch_q, count_ch_d;
  logic               overflow_q, overflow_d;

  logic meas_in;
  logic load_prev;
  logic count_en;
  logic edge_det;

  // The measurement path uses the latched channel, not the live select.
  assign meas_in  = ro_pad[ch_q];
  assign count_en = (state_q == ST_COUNT);

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .async_i   (meas_in),
    .load_prev (load_prev),
    .count_en  (count_en),
    .edge_o    (edge_det)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    win_d      = win_q;
    win_rem_d  = win_rem_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    count_ch_d = count_ch_q;
    overflow_d = overflow_q;
    load_prev  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ch_d     = sel;
          win_d    = win_len;
          settle_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (settle_q == SETTLE_LAST) begin
          load_prev = 1'b1;
          win_rem_d = win_q;
          state_d   = (win_q == '0) ? ST_DONE : ST_COUNT;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_COUNT: begin
        if (edge_det) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (win_rem_q == WIN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          win_rem_d = win_rem_q - WIN_W'(1);
        end
      end

      ST_DONE: begin
`ifdef RO_FREQ_METER_AUTO_SCAN_EN
        if (ch_q < LAST_CH) begin
          ch_d     = ch_q + CH_W'(1);
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else begin
          state_d  = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    // Publish on entry to DONE so the outputs change in the done cycle and
    // include any edge counted on the final COUNT cycle.
    if (state_d == ST_DONE) begin
      done_d     = 1'b1;
      count_d    = cnt_d;
      overflow_d = ovf_d;
      count_ch_d = ch_q;
`ifdef RO_FREQ_METER_AUTO_SCAN_EN
      busy_d     = (ch_q < LAST_CH);
`else
      busy_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      win_q      <= '0;
      win_rem_q  <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      count_ch_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      win_q      <= win_d;
      win_rem_q  <= win_rem_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      count_ch_q <= count_ch_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign count_ch = count_ch_q;
  assign overflow = overflow_q;

endmodule : ro_freq_meter
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ro_freq_meter
// Purpose : Self-checking bench for ro_freq_meter. Oscillators are square
//           waves defined as functions of the clock-edge index, so the
//           expected edge count of any window is plain arithmetic over those
//           functions. A timestamp model predicts busy/done/results per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int WIN_W  = 16;
  localparam int CNT_W  = 8;
  localparam int S      = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef RO_FREQ_METER_AUTO_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] ro_in = '0;
  logic [CH_W-1:0]   sel = '0;
  logic [WIN_W-1:0]  win_len = '0;
  logic              start = 1'b0;
  logic              busy, done, overflow, mux_out;
  logic [CNT_W-1:0]  count;
  logic [CH_W-1:0]   count_ch;

  always #5 clk = ~clk;

  ro_freq_meter #(
    .NUM_CH (NUM_CH), .CH_W (CH_W), .WIN_W (WIN_W),
    .CNT_W (CNT_W), .SYNC_STAGES (S)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .ro_in (ro_in), .sel (sel),
    .win_len (win_len), .start (start), .busy (busy), .done (done),
    .count (count), .count_ch (count_ch), .overflow (overflow),
    .mux_out (mux_out)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // index of the most recent rising clock edge

  int per [NUM_CH];   // period in cycles, 0 = constant
  int ph  [NUM_CH];
  bit cval[NUM_CH];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Oscillator value as sampled at clock edge n.
  function automatic bit wave(input int c, input int n);
    if (per[c] == 0) return cval[c];
    return ((n + ph[c]) % per[c]) < (per[c] / 2);
  endfunction

  // Start accepted at edge e: the first fresh sample is taken at e+1, and
  // the window sees the w transitions between samples e+1 .. e+w+1.
  function automatic int rising(input int c, input int e, input int w);
    int r = 0;
    for (int n = e + 2; n <= e + w + 1; n++)
      if (wave(c, n) && !wave(c, n - 1)) r++;
    return r;
  endfunction

  // ---------------- timestamp model ----------------
  bit m_active = 0;
  int m_done_edge, m_ch, m_w, m_raw;
  bit e_busy = 0, e_done = 0, e_ovf = 0, prev_done;
  int e_count = 0, e_ch = 0;

  task automatic launch(input int e);
    m_done_edge = e + S + 1 + m_w;
    m_raw       = rising(m_ch, e, m_w);
    m_active    = 1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) begin
      m_active = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_count = 0; e_ch = 0;
    end else begin
      prev_done = e_done;
      e_done    = 0;
      if (m_active && cyc == m_done_edge) begin
        e_done  = 1;
        e_count = (m_raw > CMAX) ? CMAX : m_raw;
        e_ovf   = (m_raw > CMAX);
        e_ch    = m_ch;
        if (SCAN && m_ch < NUM_CH - 1) begin
          m_ch = m_ch + 1;
          launch(cyc + 1);
        end else begin
          m_active = 0;
          e_busy   = 0;
        end
      end else if (!m_active && !prev_done && start) begin
        m_ch = int'(sel);
        m_w  = int'(win_len);
        launch(cyc);
        e_busy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #2;
    check("busy",     int'(busy),     int'(e_busy));
    check("done",     int'(done),     int'(e_done));
    check("count",    int'(count),    e_count);
    check("count_ch", int'(count_ch), e_ch);
    check("overflow", int'(overflow), int'(e_ovf));
    check("mux_out",  int'(mux_out),  int'(ro_in[sel]));
  end

  // Oscillators change away from the sampling edge.
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) ro_in[c] = wave(c, cyc + 1);
  end

  // ---------------- directed / random runs ----------------
  task automatic run(input int s, input int w, input int exp_cnt, input int exp_ovf,
                     input int exp_lat, input bit poke_done, input bit poke_mid,
                     input string tag, output int bcnt);
    int k0, lat, ndone, first_cnt, first_ovf, i;
    bit fin;
    @(negedge clk);
    sel = CH_W'(s); win_len = WIN_W'(w); start = 1'b1; k0 = cyc;
    @(negedge clk);
    start = 1'b0;
    sel = CH_W'($urandom_range(0, NUM_CH - 1));
    win_len = WIN_W'($urandom_range(0, 65535));
    fin = 0; ndone = 0; bcnt = 0; lat = -1; first_cnt = -1; first_ovf = -1; i = 0;
    while (!fin && i < 40000) begin
      start = 1'b0;
      if (busy) bcnt++;
      if (poke_mid && i == S + 3) start = 1'b1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = cyc - k0; first_cnt = int'(count); first_ovf = int'(overflow);
        end
        if (!busy) fin = 1;
        if (poke_done) start = 1'b1;
      end
      i++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_finished"}, int'(fin), 1);
    check({tag, "_idle_after"}, int'(busy), 0);
    check({tag, "_ndone"}, ndone, SCAN ? (NUM_CH - s) : 1);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    if (exp_cnt >= 0) check({tag, "_count"}, first_cnt, exp_cnt);
    if (exp_ovf >= 0) check({tag, "_ovf"}, first_ovf, exp_ovf);
  endtask

  initial begin
    int bc, nd;
    for (int c = 0; c < NUM_CH; c++) begin
      per[c] = $urandom_range(2, 40); ph[c] = $urandom_range(0, 99); cval[c] = 0;
    end
    per[3] = 10;
    per[5] = 0; cval[5] = 1;
    per[6] = 0; cval[6] = 0;
    per[7] = 2;

    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1; sel = 4'd3; win_len = 16'd5;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    // 100 transitions of a period-10 wave contain exactly 10 rising edges.
    run(3, 100, 10, 0, 104, 1'b1, 1'b0, "ch3", bc);
    if (!SCAN) check("ch3_busy_cycles", bc, 103);
    run(3, 0, 0, 0, 4, 1'b0, 1'b0, "win0", bc);
    run(5, 50, 0, 0, 54, 1'b0, 1'b0, "const1", bc);
    run(7, 600, CMAX, 1, 604, 1'b0, 1'b0, "sat", bc);
    run(7, 20, 10, 0, 24, 1'b0, 1'b0, "after_sat", bc);
    run(9, 80, -1, -1, 84, 1'b1, 1'b1, "poke_mid", bc);

    // Reset in the middle of the counting window.
    @(negedge clk);
    sel = 4'd4; win_len = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    nd = 0;
    repeat (250) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);

    // Randomized runs; expectations come from the per-cycle model.
    for (int r = 0; r < 10; r++) begin
      int s, w;
      s = $urandom_range(0, NUM_CH - 1);
      w = $urandom_range(0, 150);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run(s, w, -1, -1, S + 2 + w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          "rand", bc);
    end

    if (SCAN) run(13, 40, -1, -1, 44, 1'b0, 1'b0, "scan13", bc);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ro_freq_meter
`default_nettype wire

// File: doc/ro_freq_meter.md
# ro_freq_meter

Parametrised ring-oscillator frequency meter for the user project area. It replaces the fixed 16:1 oscillator select mux with an N-channel select plus a gated edge counter. The counter measures the selected oscillator over a programmable window of `wb_clk_i` cycles and reports the edge count with a start/busy/done handshake. The raw selected oscillator is still forwarded combinationally, so it can be probed on a GPIO as before.

## Interface
- `NUM_CH`, 16: number of oscillator channels, 2..64.
- `CH_W`, `$clog2(NUM_CH)`: channel index width.
- `WIN_W`, 16: window-length width, in clock cycles.
- `CNT_W`, 24: edge-count width.
- `SYNC_STAGES`, 2: synchronizer depth, ≥2.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `ro_in`  in  NUM_CH  asynchronous ring-oscillator outputs.
- `sel`  in  CH_W  channel to measure; sampled on an accepted `start`.
- `win_len`  in  WIN_W  window length in cycles; sampled on an accepted `start`.
- `start`  in  1  request pulse or level; accepted only in IDLE.
- `busy`  out  1  measurement in progress.
- `done`  out  1  one-cycle pulse when a result is published.
- `count`  out  CNT_W  rising edges counted in the last window.
- `count_ch`  out  CH_W  channel that `count` belongs to.
- `overflow`  out  1  the last window saturated `count`.
- `mux_out`  out  1  raw `ro_in[sel]`, combinational, unsynchronized; 0 if `sel` ≥ `NUM_CH`.

## Operation
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE: on `start`=1, latch `sel`→`ch_q` and `win_len`→`win_q`, then go to SETTLE.
- SETTLE: lasts `SYNC_STAGES`+1 cycles.
  - Flushes the synchronizer after the mux switch.
  - On its last cycle, loads the previous-sample register from the synchronizer output, so the first COUNT cycle cannot produce a false edge.
  - Clears the edge counter and the overflow flag.
  - Goes to COUNT, or straight to DONE if `win_q`==0.
- COUNT: lasts exactly `win_q` cycles.
  - Each cycle, edge = `sync_out & ~prev`.
  - Edge counter increments and saturates at 2^CNT_W−1.
  - An edge arriving while the counter is saturated sets `overflow`.
- DONE: one cycle.
  - Publish `count`, `count_ch`=`ch_q`, `overflow`.
  - Pulse `done`.
  - Return to IDLE.
- Channel `ch_q` ≥ `NUM_CH` selects constant 0, giving `count`=0 and `overflow`=0.
- `start` outside IDLE (including the DONE cycle) is ignored; it is not queued.
- `sel` and `win_len` changes during a measurement do not affect it; `mux_out` follows `sel` live.
- Measurement is valid only for f_ro < f_clk/2; faster inputs alias. This is documented, not detected.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `count_ch`=0, `overflow`=0; state IDLE; synchronizer flops 0.
- `start` sampled high at edge E (IDLE) → `busy`=1 from E+1.
- `done`=1 in cycle E+1+(`SYNC_STAGES`+1)+`win_q`; `busy`=0 in that same cycle.
- `count`/`count_ch`/`overflow` change only in the `done` cycle and hold until the next `done`.
- An edge detected on the final COUNT cycle is included.
- Reset mid-measurement: abort on the next edge, all outputs return to reset values, no `done`.
- Earliest next `start` acceptance is the cycle after `done`.

## Configuration
- Macro: `RO_FREQ_METER_AUTO_SCAN_EN`.
- Defined: an accepted `start` launches a scan.
  - After each DONE, if `ch_q` < `NUM_CH`−1, increment `ch_q` and re-enter SETTLE with the same `win_q`; otherwise return to IDLE.
  - `done` pulses once per channel; `busy` stays 1 throughout, including the intermediate DONE cycles.
  - `busy` drops only on the final DONE.
- Undefined: single-shot measurement, exactly as described above.

## Structure
- Package `ro_meter_pkg`: state enum (IDLE, SETTLE, COUNT, DONE) and default parameter constants.
- Sub-module `ro_sync_edge`: `SYNC_STAGES`-deep synchronizer plus previous-sample register, with edge and load-prev control.
- Top level holds the mux, FSM, window counter and edge counter.

## Test plan
- Reset: hold `wb_rst_i` 3 cycles with `start`=1 → all outputs 0, no `done`.
- Ch 3 square wave period 10 clk, `win_len`=100, `SYNC_STAGES`=2 → `done` exactly 104 cycles after `start`; `count`∈{9,10}; `count_ch`=3; `busy` high 103 cycles.
- `win_len`=0 → `done` 4 cycles after `start`, `count`=0; constant-1 channel over 50 cycles → `count`=0 (no false first edge).
- `CNT_W`=4, period 4, `win_len`=100 → `count`=15, `overflow`=1; next run with `win_len`=20 → `overflow`=0, `count`=5±1.
- `start` during COUNT and during DONE → ignored; `wb_rst_i` in mid-COUNT → `busy`=0 next cycle, no `done`.
- With `RO_FREQ_METER_AUTO_SCAN_EN`, `sel`=13, `NUM_CH`=16 → 3 `done` pulses with `count_ch`=13,14,15, `busy` continuous, then IDLE.
